// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and flag bit positions used by
// the pipelined add/subtract unit.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD      = 2'b00,
    OP_SUB      = 2'b01,
    OP_SUBU_SAT = 2'b10,
    OP_SUBS_SAT = 2'b11
  } op_e;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_NEG   = 3;
  localparam int NUM_FLAGS  = 4;

endpackage

// File: rtl/addsub_chunk.sv
// One slice of the split carry chain: CW-bit add with carry-in, returning the
// carry-out and the carry into the slice MSB (used for signed overflow).
module addsub_chunk #(
  parameter int CW = 16
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          cmsb
);

  logic [CW:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  assign sum  = full[CW-1:0];
  assign cout = full[CW];
  // Carry into the MSB recovered from the MSB sum bit; works for CW == 1 too.
  assign cmsb = full[CW-1] ^ a[CW-1] ^ b[CW-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract with wrap or saturating modes; stage k adds
// operand chunk k, and the whole pipe advances as one under valid/ready.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int CW = WIDTH / STAGES;

  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:k*CW]    a_src;   // operand chunks k.. still to be added
    logic [WIDTH-1:k*CW]    b_src;
    logic [k*CW+CW-1:0]     s_new;   // result chunks 0..k
    logic                   cin;
    logic                   v_src;
    op_e                    op_src;
    logic [CW-1:0]          sum;
    logic                   cout;
    logic                   valid_q;

    if (k == 0) begin : g_src
      assign op_src = op_e'(op);
      assign a_src  = in1;
      assign b_src  = (op_src == OP_ADD) ? in2 : ~in2;
      assign cin    = (op_src != OP_ADD);
      assign v_src  = in_valid;
      assign s_new  = sum;
    end else begin : g_src
      assign op_src = g_stage[k-1].g_mid.op_q;
      assign a_src  = g_stage[k-1].g_mid.a_q;
      assign b_src  = g_stage[k-1].g_mid.b_q;
      assign cin    = g_stage[k-1].g_mid.c_q;
      assign v_src  = g_stage[k-1].valid_q;
      assign s_new  = {sum, g_stage[k-1].g_mid.s_q};
    end

    // NOTE: sequential state is always assigned with <= so every stage samples
    // the previous stage's pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)    valid_q <= 1'b0;
      else if (adv) valid_q <= v_src;
    end

    if (k < STAGES - 1) begin : g_mid
      logic                  cmsb_unused;
      logic [WIDTH-1:(k+1)*CW] a_q;
      logic [WIDTH-1:(k+1)*CW] b_q;
      logic [(k+1)*CW-1:0]   s_q;
      logic                  c_q;
      op_e                   op_q;

      addsub_chunk #(.CW(CW)) u_chunk (
        .a    (a_src[k*CW +: CW]),
        .b    (b_src[k*CW +: CW]),
        .cin  (cin),
        .sum  (sum),
        .cout (cout),
        .cmsb (cmsb_unused)
      );

      // NOTE: datapath registers are reset as well, so a discarded beat can
      // never leave residue that is observable after reset.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q  <= '0;
          b_q  <= '0;
          s_q  <= '0;
          c_q  <= 1'b0;
          op_q <= OP_ADD;
        end else if (adv && v_src) begin
          a_q  <= a_src[WIDTH-1:(k+1)*CW];
          b_q  <= b_src[WIDTH-1:(k+1)*CW];
          s_q  <= s_new;
          c_q  <= cout;
          op_q <= op_src;
        end
      end
    end else begin : g_last
      logic                 cmsb;
      logic                 ovf_raw;
      logic [WIDTH-1:0]     res;
      logic [NUM_FLAGS-1:0] flags_d;
      logic [NUM_FLAGS-1:0] flags_q;
      logic [WIDTH-1:0]     out_q;

      addsub_chunk #(.CW(CW)) u_chunk (
        .a    (a_src[k*CW +: CW]),
        .b    (b_src[k*CW +: CW]),
        .cin  (cin),
        .sum  (sum),
        .cout (cout),
        .cmsb (cmsb)
      );

      assign ovf_raw = cmsb ^ cout;

      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      always_comb begin
        res     = s_new;
        flags_d = '0;
        if (op_src == OP_SUBU_SAT && !cout)
          res = '0;
        else if (op_src == OP_SUBS_SAT && ovf_raw)
          res = a_src[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        // carry/ovf describe the raw operation; zero/neg the clamped result.
        flags_d[FLAG_CARRY] = (op_src == OP_ADD) ? cout : ~cout;
        flags_d[FLAG_OVF]   = ovf_raw;
        flags_d[FLAG_ZERO]  = (res == '0);
        flags_d[FLAG_NEG]   = res[WIDTH-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          out_q   <= '0;
          flags_q <= '0;
        end else if (adv && v_src) begin
          out_q   <= res;
          flags_q <= flags_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign Out       = g_stage[STAGES-1].g_last.out_q;
  assign carry     = g_stage[STAGES-1].g_last.flags_q[FLAG_CARRY];
  assign ovf       = g_stage[STAGES-1].g_last.flags_q[FLAG_OVF];
  assign zero      = g_stage[STAGES-1].g_last.flags_q[FLAG_ZERO];
  assign neg       = g_stage[STAGES-1].g_last.flags_q[FLAG_NEG];

endmodule
